scale_row_sequencer: RTL and testbench
======================================

Name: scale_row_sequencer

Overview:
- Parametrised output-row sequencer for the scaler datapath.
- Per output row: requests a line-buffer fill, waits for `tran_done`, then issues column read addresses to the line buffer.
- Columns beyond the active width are replaced with a pad pixel; pixels are returned to the downstream writer over a valid/ready handshake.
- Succeeds the fixed 640x360 sequencer with runtime window geometry, multi-channel pixels, configurable read latency, backpressure and restartable frames.

Parameters:
- PIX_WIDTH, 16, bits per channel
- CH_NUM, 1, channels per pixel; data buses are PIX_WIDTH*CH_NUM wide
- COL_W, 11, column counter / x_pos width
- ROW_W, 11, row counter / dst_row width
- RD_LAT, 2, line-buffer read latency in cycles (rd_en to input_data), 1..4
- FIFO_DEPTH, RD_LAT+2, output skid FIFO depth

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- frame_start  in  1  pulse: latch config, start a frame
- win_h_num  in  COL_W  columns per output row
- win_v_num  in  ROW_W  rows per frame
- act_h_num  in  COL_W  active columns; columns > act_h_num are padded
- row_start  in  ROW_W  first dst_row value
- pad_value  in  PIX_WIDTH*CH_NUM  pixel emitted for padded columns
- wr_req  out  1  line-fill request, high while in WAIT
- tran_done  in  1  line buffer filled for current dst_row
- dst_row  out  ROW_W  current output row
- rd_en  out  1  line-buffer read strobe
- x_pos  out  COL_W  line-buffer column address, 1-based, valid with rd_en
- input_data  in  PIX_WIDTH*CH_NUM  read data, RD_LAT cycles after rd_en
- out_data  out  PIX_WIDTH*CH_NUM  FIFO head pixel
- data_valid  out  1  FIFO non-empty
- out_ready  in  1  downstream accepts; pop when data_valid && out_ready
- row_done  out  1  one-cycle pulse at end of each row
- frame_done  out  1  level: frame complete

Behaviour:
- Reset values:
  - Outputs: wr_req=0, rd_en=0, x_pos=1, dst_row=0, data_valid=0, out_data=0, row_done=0, frame_done=0.
  - Internal: FIFO empty, in-flight pipe cleared.
  - Reset asserted mid-frame aborts the frame immediately; state returns to IDLE.
- States: IDLE, WAIT, RUN, DRAIN, DONE, FRAME_DONE.
- Config latching:
  - win_h_num, win_v_num, act_h_num, row_start and pad_value are latched on frame_start in IDLE or FRAME_DONE.
  - frame_start in any other state is ignored; input changes mid-frame have no effect.
- IDLE or FRAME_DONE + frame_start:
  - If latched win_h_num==0 or win_v_num==0: go to FRAME_DONE with frame_done=1.
  - Else: dst_row<=row_start, frame_done<=0, go to WAIT.
- WAIT:
  - wr_req=1.
  - tran_done=1 -> RUN, with x_pos=1.
  - tran_done in any other state is ignored.
- RUN, read issue:
  - rd_en=1 in a cycle only when credit>0, where credit = FIFO_DEPTH - fifo_count - inflight_count.
  - x_pos increments after each issued read.
  - After issuing x_pos==win_h_num -> DRAIN.
  - While credit==0, rd_en=0 and x_pos holds (backpressure stall).
- Pad tag:
  - Each issued read carries a tag: pad = (x_pos > act_h_num).
  - The tag travels with an RD_LAT-stage valid pipe.
  - At the pipe output, FIFO writes pad_value if tag set, else input_data.
  - act_h_num >= win_h_num gives no padding; act_h_num==0 pads the whole row.
- DRAIN:
  - Wait until inflight_count==0 and FIFO empty (last pixel popped), then -> DONE.
- DONE, one cycle:
  - row_done=1.
  - If dst_row == row_start+win_v_num-1 (mod 2^ROW_W): -> FRAME_DONE, frame_done=1, dst_row holds.
  - Else: dst_row+1 -> WAIT.
- Latency:
  - First pixel data_valid appears RD_LAT+1 cycles after the first rd_en.
  - With out_ready held 1, one pixel per cycle after that, no bubbles.
- FIFO:
  - Simultaneous push and pop allowed on full or empty.
  - Credit accounting guarantees no overflow; an overflow is a design error.
- Width rules:
  - x_pos and dst_row compare at full width.
  - The last-row sum wraps modulo 2^ROW_W.

Test Plan:
- frame_start with win 8x3, act 8, row_start=5, RD_LAT=2, out_ready=1, tran_done 4 cycles after each wr_req -> 3 rows of 8 pixels each, contiguous.
  - dst_row 5,6,7.
  - row_done pulses 3 times.
  - frame_done=1 after the third row.
  - First data_valid 3 cycles after the first rd_en.
- win 10x1, act 6, pad_value=16'hABCD, line data = x_pos -> out_data sequence 1..6 then four 16'hABCD.
- out_ready toggling 1 cycle on, 3 off during a 16-column row -> no lost or duplicated pixels; rd_en stalls at credit 0; FIFO never exceeds FIFO_DEPTH.
- frame_start with win_v_num=0 -> frame_done=1 within 2 cycles; no wr_req, no rd_en.
- rstn low during RUN column 5 -> all outputs at reset values that cycle; a new frame_start restarts from row_start, x_pos=1.
- frame_start pulsed mid-frame, and tran_done pulsed during RUN -> both ignored; row count and pixel count unchanged.

Source files
------------

// File: rtl/scale_row_sequencer.sv
// -----------------------------------------------------------------------------
// scale_row_sequencer
//
// Output-row sequencer for the scaler datapath. For every output row it asks
// the line buffer to fill (wr_req), waits for tran_done, then issues 1-based
// column reads (rd_en/x_pos). Read data returns RD_LAT cycles later. Columns
// beyond the active width are replaced by pad_value. Pixels are handed to the
// downstream writer through a small skid FIFO with a valid/ready handshake.
// Reads are throttled by a credit count, so the FIFO can never overflow.
//
// Ports:
//   clk, rstn         clock, asynchronous active-low reset
//   frame_start       pulse: latch window config and start a frame
//   win_h_num         columns per output row
//   win_v_num         rows per frame
//   act_h_num         active columns (columns > act_h_num are padded)
//   row_start         first dst_row value
//   pad_value         pixel emitted for padded columns
//   wr_req            line-fill request (high while waiting for tran_done)
//   tran_done         line buffer filled for current dst_row
//   dst_row           current output row
//   rd_en, x_pos      line-buffer read strobe and 1-based column address
//   input_data        line-buffer read data, RD_LAT cycles after rd_en
//   out_data          FIFO head pixel (0 when empty)
//   data_valid        FIFO non-empty
//   out_ready         downstream accepts; pop on data_valid && out_ready
//   row_done          one-cycle pulse at the end of each row
//   frame_done        level: frame complete
// -----------------------------------------------------------------------------
module scale_row_sequencer #(
  parameter int PIX_WIDTH  = 16,
  parameter int CH_NUM     = 1,
  parameter int COL_W      = 11,
  parameter int ROW_W      = 11,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = RD_LAT + 2
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        frame_start,
  input  logic [COL_W-1:0]            win_h_num,
  input  logic [ROW_W-1:0]            win_v_num,
  input  logic [COL_W-1:0]            act_h_num,
  input  logic [ROW_W-1:0]            row_start,
  input  logic [PIX_WIDTH*CH_NUM-1:0] pad_value,
  output logic                        wr_req,
  input  logic                        tran_done,
  output logic [ROW_W-1:0]            dst_row,
  output logic                        rd_en,
  output logic [COL_W-1:0]            x_pos,
  input  logic [PIX_WIDTH*CH_NUM-1:0] input_data,
  output logic [PIX_WIDTH*CH_NUM-1:0] out_data,
  output logic                        data_valid,
  input  logic                        out_ready,
  output logic                        row_done,
  output logic                        frame_done
);

  localparam int DW    = PIX_WIDTH * CH_NUM;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WAIT       = 3'd1;
  localparam logic [2:0] S_RUN        = 3'd2;
  localparam logic [2:0] S_DRAIN      = 3'd3;
  localparam logic [2:0] S_DONE       = 3'd4;
  localparam logic [2:0] S_FRAME_DONE = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [COL_W-1:0] win_h_q, win_h_d;
  logic [ROW_W-1:0] win_v_q, win_v_d;
  logic [COL_W-1:0] act_h_q, act_h_d;
  logic [ROW_W-1:0] row_start_q, row_start_d;
  logic [DW-1:0]    pad_q, pad_d;
  logic [ROW_W-1:0] dst_row_q, dst_row_d;
  logic [COL_W-1:0] x_pos_q, x_pos_d;
  logic             frame_done_q, frame_done_d;

  // Read-latency pipe: one valid bit and one pad tag per outstanding read.
  logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
  logic [RD_LAT-1:0] pipe_pad_q, pipe_pad_d;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [DW-1:0]    mem [FIFO_DEPTH];

  logic [CNT_W-1:0] inflight_cnt;
  logic             credit_ok;
  logic             push, pop;
  logic [DW-1:0]    push_data;
  logic [ROW_W-1:0] last_row;

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_cnt = inflight_cnt + CNT_W'(pipe_vld_q[i]);
    end
  end

  // Every read in flight already owns a FIFO slot, so the sum of occupancy
  // and in-flight reads must stay below the depth before a new read issues.
  assign credit_ok = ({1'b0, fifo_cnt_q} + {1'b0, inflight_cnt}) < DEPTH_C;

  assign rd_en      = (state_q == S_RUN) && credit_ok;
  assign wr_req     = (state_q == S_WAIT);
  assign row_done   = (state_q == S_DONE);
  assign frame_done = frame_done_q;
  assign dst_row    = dst_row_q;
  assign x_pos      = x_pos_q;

  assign push       = pipe_vld_q[RD_LAT-1];
  assign push_data  = pipe_pad_q[RD_LAT-1] ? pad_q : input_data;
  assign data_valid = (fifo_cnt_q != '0);
  assign pop        = data_valid && out_ready;
  assign out_data   = data_valid ? mem[rd_ptr_q] : '0;

  // Last row index wraps modulo 2^ROW_W, matching dst_row's own wrap.
  assign last_row = row_start_q + win_v_q - ROW_W'(1);

  always_comb begin
    pipe_vld_d[0] = rd_en;
    pipe_pad_d[0] = (x_pos_q > act_h_q);
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_pad_d[i] = pipe_pad_q[i-1];
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
    end else if (!push && pop) begin
      fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    win_h_d      = win_h_q;
    win_v_d      = win_v_q;
    act_h_d      = act_h_q;
    row_start_d  = row_start_q;
    pad_d        = pad_q;
    dst_row_d    = dst_row_q;
    x_pos_d      = x_pos_q;
    frame_done_d = frame_done_q;
    case (state_q)
      S_IDLE, S_FRAME_DONE: begin
        if (frame_start) begin
          win_h_d     = win_h_num;
          win_v_d     = win_v_num;
          act_h_d     = act_h_num;
          row_start_d = row_start;
          pad_d       = pad_value;
          // An empty window completes immediately without touching the buffer.
          if (win_h_num == '0 || win_v_num == '0) begin
            state_d      = S_FRAME_DONE;
            frame_done_d = 1'b1;
          end else begin
            dst_row_d    = row_start;
            frame_done_d = 1'b0;
            state_d      = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (tran_done) begin
          x_pos_d = COL_W'(1);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (rd_en) begin
          x_pos_d = x_pos_q + COL_W'(1);
          if (x_pos_q == win_h_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (inflight_cnt == '0 && fifo_cnt_q == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (dst_row_q == last_row) begin
          frame_done_d = 1'b1;
          state_d      = S_FRAME_DONE;
        end else begin
          dst_row_d = dst_row_q + ROW_W'(1);
          state_d   = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      win_h_q      <= '0;
      win_v_q      <= '0;
      act_h_q      <= '0;
      row_start_q  <= '0;
      pad_q        <= '0;
      dst_row_q    <= '0;
      x_pos_q      <= COL_W'(1);
      frame_done_q <= 1'b0;
      pipe_vld_q   <= '0;
      pipe_pad_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      win_h_q      <= win_h_d;
      win_v_q      <= win_v_d;
      act_h_q      <= act_h_d;
      row_start_q  <= row_start_d;
      pad_q        <= pad_d;
      dst_row_q    <= dst_row_d;
      x_pos_q      <= x_pos_d;
      frame_done_q <= frame_done_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_pad_q   <= pipe_pad_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: tb/tb_scale_row_sequencer.sv
// -----------------------------------------------------------------------------
// tb_scale_row_sequencer
//
// Self-checking bench for scale_row_sequencer. A line-buffer model returns
// {dst_row[4:0], x_pos} RD_LAT cycles after each read. At every accepted
// frame_start the reference model builds the full expected pixel stream and
// the list of rows from the frame rules. A negedge process drives out_ready
// and tran_done and compares the DUT against that model every cycle.
// -----------------------------------------------------------------------------
module tb_scale_row_sequencer;

  localparam int PW     = 16;
  localparam int CH     = 1;
  localparam int COL_W  = 11;
  localparam int ROW_W  = 11;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = RD_LAT + 2;
  localparam int DW     = PW * CH;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             frame_start = 1'b0;
  logic [COL_W-1:0] win_h_num = '0;
  logic [ROW_W-1:0] win_v_num = '0;
  logic [COL_W-1:0] act_h_num = '0;
  logic [ROW_W-1:0] row_start = '0;
  logic [DW-1:0]    pad_value = '0;
  logic             wr_req;
  logic             tran_done = 1'b0;
  logic [ROW_W-1:0] dst_row;
  logic             rd_en;
  logic [COL_W-1:0] x_pos;
  logic [DW-1:0]    input_data;
  logic [DW-1:0]    out_data;
  logic             data_valid;
  logic             out_ready = 1'b1;
  logic             row_done;
  logic             frame_done;

  scale_row_sequencer #(
    .PIX_WIDTH (PW),
    .CH_NUM    (CH),
    .COL_W     (COL_W),
    .ROW_W     (ROW_W),
    .RD_LAT    (RD_LAT),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .frame_start(frame_start),
    .win_h_num  (win_h_num),
    .win_v_num  (win_v_num),
    .act_h_num  (act_h_num),
    .row_start  (row_start),
    .pad_value  (pad_value),
    .wr_req     (wr_req),
    .tran_done  (tran_done),
    .dst_row    (dst_row),
    .rd_en      (rd_en),
    .x_pos      (x_pos),
    .input_data (input_data),
    .out_data   (out_data),
    .data_valid (data_valid),
    .out_ready  (out_ready),
    .row_done   (row_done),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] line_pix(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] x);
    return {r[4:0], x};
  endfunction

  // Line-buffer model: data for the addressed column, RD_LAT cycles later.
  logic [DW-1:0] lb_q [RD_LAT];
  always @(posedge clk) begin
    lb_q[0] <= rd_en ? line_pix(dst_row, x_pos) : DW'('hDEAD);
    for (int i = 1; i < RD_LAT; i++) lb_q[i] <= lb_q[i-1];
  end
  assign input_data = lb_q[RD_LAT-1];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state
  logic [DW-1:0]    exp_pix[$];
  logic [DW-1:0]    got_q[$];
  logic [ROW_W-1:0] m_rows[$];
  logic [ROW_W-1:0] seen_rows[$];
  int  m_win_h, row_idx, issued_row, popped_row, first_rd_cyc, rows_done_cnt;
  int  last_lat, max_out;
  bit  dv_seen, prev_fd;
  int  rdy_mode = 0;
  int  td_delay = 4;
  int  td_cnt   = 0;
  bit  stray_td = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_start(input int wh, input int wv, input int act,
                             input logic [ROW_W-1:0] rs, input logic [DW-1:0] pad);
    logic [ROW_W-1:0] row;
    exp_pix.delete(); got_q.delete(); m_rows.delete(); seen_rows.delete();
    m_win_h = wh; row_idx = 0; issued_row = 0; popped_row = 0;
    rows_done_cnt = 0; dv_seen = 1'b0; max_out = 0; last_lat = -1;
    if (wh != 0 && wv != 0) begin
      for (int r = 0; r < wv; r++) begin
        row = rs + ROW_W'(r);
        m_rows.push_back(row);
        for (int x = 1; x <= wh; x++)
          exp_pix.push_back((x > act) ? pad : line_pix(row, COL_W'(x)));
      end
    end
  endtask

  task automatic monitor_cycle();
    logic [DW-1:0] e;
    if (wr_req) begin
      check("wr_req_row_exists", 64'(row_idx < m_rows.size()), 64'(1));
      if (row_idx < m_rows.size()) check("wr_req_dst_row", 64'(dst_row), 64'(m_rows[row_idx]));
    end
    if (rd_en) begin
      check("rd_en_expected", 64'((row_idx < m_rows.size()) && (issued_row < m_win_h)), 64'(1));
      check("rd_credit", 64'((issued_row - popped_row) < DEPTH), 64'(1));
      check("x_pos", 64'(x_pos), 64'(issued_row + 1));
      if (row_idx < m_rows.size()) check("rd_dst_row", 64'(dst_row), 64'(m_rows[row_idx]));
      if (issued_row == 0) first_rd_cyc = cyc;
      issued_row++;
      if (issued_row - popped_row > max_out) max_out = issued_row - popped_row;
    end
    if (data_valid && !dv_seen) begin
      last_lat = cyc - first_rd_cyc;
      check("first_pixel_latency", 64'(last_lat), 64'(RD_LAT + 1));
      dv_seen = 1'b1;
    end else if (rdy_mode == 0 && dv_seen && popped_row > 0 && popped_row < m_win_h) begin
      check("no_bubble", 64'(data_valid), 64'(1));
    end
    if (data_valid && out_ready) begin
      check("pixel_expected", 64'(exp_pix.size() != 0), 64'(1));
      if (exp_pix.size() != 0) begin
        e = exp_pix.pop_front();
        check("out_data", 64'(out_data), 64'(e));
      end
      got_q.push_back(out_data);
      popped_row++;
    end
    if (row_done) begin
      check("row_done_expected", 64'(row_idx < m_rows.size()), 64'(1));
      if (row_idx < m_rows.size()) check("row_done_dst_row", 64'(dst_row), 64'(m_rows[row_idx]));
      check("row_reads", 64'(issued_row), 64'(m_win_h));
      check("row_pops", 64'(popped_row), 64'(m_win_h));
      seen_rows.push_back(dst_row);
      row_idx++; issued_row = 0; popped_row = 0; dv_seen = 1'b0; rows_done_cnt++;
    end
    if (frame_done && !prev_fd) begin
      check("frame_rows", 64'(row_idx), 64'(m_rows.size()));
      check("frame_pixels_left", 64'(exp_pix.size()), 64'(0));
    end
    prev_fd = frame_done;
  endtask

  // Responder + comparator: drive ready/tran_done, then compare 1 unit later.
  initial begin
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 4 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (wr_req) begin
        tran_done = (td_cnt == td_delay);
        td_cnt++;
      end else begin
        tran_done = stray_td && rd_en;
        if (tran_done) stray_td = 1'b0;
        td_cnt = 0;
      end
      #1;
      cyc++;
      if (rstn) monitor_cycle();
    end
  end

  task automatic start_frame(input int wh, input int wv, input int act,
                             input logic [ROW_W-1:0] rs, input logic [DW-1:0] pad);
    @(negedge clk);
    win_h_num = COL_W'(wh); win_v_num = ROW_W'(wv); act_h_num = COL_W'(act);
    row_start = rs; pad_value = pad; frame_start = 1'b1;
    model_start(wh, wv, act, rs, pad);
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_frame(input int limit);
    for (int n = 0; n < limit; n++) begin
      @(negedge clk); #2;
      if (frame_done) break;
    end
    check("frame_done_reached", 64'(frame_done), 64'(1));
  endtask

  task automatic check_reset_outputs();
    check("rst_wr_req", 64'(wr_req), 64'(0));
    check("rst_rd_en", 64'(rd_en), 64'(0));
    check("rst_x_pos", 64'(x_pos), 64'(1));
    check("rst_dst_row", 64'(dst_row), 64'(0));
    check("rst_data_valid", 64'(data_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_row_done", 64'(row_done), 64'(0));
    check("rst_frame_done", 64'(frame_done), 64'(0));
  endtask

  initial begin
    logic [DW-1:0] pad_exp [10];
    bit found;
    model_start(0, 0, 0, '0, '0);
    prev_fd = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_reset_outputs();
    @(negedge clk); rstn = 1'b1;

    // 8x3 frame from row 5, ready always high
    rdy_mode = 0; td_delay = 4;
    start_frame(8, 3, 8, ROW_W'(5), 16'h5555);
    wait_frame(2000);
    check("t1_pixels", 64'(got_q.size()), 64'(24));
    check("t1_row_done_cnt", 64'(rows_done_cnt), 64'(3));
    if (seen_rows.size() == 3) begin
      check("t1_row0", 64'(seen_rows[0]), 64'(5));
      check("t1_row1", 64'(seen_rows[1]), 64'(6));
      check("t1_row2", 64'(seen_rows[2]), 64'(7));
    end else check("t1_rows_seen", 64'(seen_rows.size()), 64'(3));
    check("t1_latency", 64'(last_lat), 64'(3));
    if (got_q.size() > 0) check("t1_first_pix", 64'(got_q[0]), 64'(16'h2801));

    // 10x1, act 6: 1..6 then four pads
    start_frame(10, 1, 6, ROW_W'(0), 16'hABCD);
    wait_frame(2000);
    for (int i = 0; i < 10; i++) pad_exp[i] = (i < 6) ? DW'(i + 1) : 16'hABCD;
    check("t2_pixels", 64'(got_q.size()), 64'(10));
    for (int i = 0; i < 10 && i < got_q.size(); i++) check("t2_pix", 64'(got_q[i]), 64'(pad_exp[i]));

    // 16 columns with ready 1-on/3-off: credit stalls
    rdy_mode = 1; td_delay = 2;
    start_frame(16, 1, 12, ROW_W'(100), 16'h0F0F);
    wait_frame(2000);
    check("t3_pixels", 64'(got_q.size()), 64'(16));
    check("t3_max_outstanding", 64'(max_out), 64'(DEPTH));
    if (got_q.size() == 16) begin
      check("t3_pix0", 64'(got_q[0]), 64'(16'h2001));
      check("t3_pad", 64'(got_q[12]), 64'(16'h0F0F));
    end

    // empty window
    rdy_mode = 0;
    start_frame(5, 0, 5, ROW_W'(3), 16'h0);
    #2 check("t4_frame_done_fast", 64'(frame_done), 64'(1));
    repeat (5) @(negedge clk);
    check("t4_no_rows", 64'(rows_done_cnt), 64'(0));

    // reset during column 5
    start_frame(12, 2, 12, ROW_W'(40), 16'h0);
    found = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk); #2;
      if (rd_en && x_pos == COL_W'(5)) begin found = 1'b1; break; end
    end
    check("t5_reached_col5", 64'(found), 64'(1));
    rstn = 1'b0;
    #1 check_reset_outputs();
    model_start(0, 0, 0, '0, '0);
    prev_fd = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    start_frame(6, 2, 4, ROW_W'(40), 16'h1234);
    wait_frame(2000);
    check("t5_pixels", 64'(got_q.size()), 64'(12));
    if (seen_rows.size() == 2) begin
      check("t5_row0", 64'(seen_rows[0]), 64'(40));
      check("t5_row1", 64'(seen_rows[1]), 64'(41));
    end else check("t5_rows_seen", 64'(seen_rows.size()), 64'(2));
    if (got_q.size() == 12) begin
      check("t5_pix0", 64'(got_q[0]), 64'(16'h4001));
      check("t5_pad", 64'(got_q[4]), 64'(16'h1234));
    end

    // stray frame_start and tran_done mid-frame, rows wrap past 2047
    rdy_mode = 2; td_delay = 1;
    start_frame(9, 3, 7, ROW_W'(2046), 16'h7777);
    found = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk); #2;
      if (rd_en) begin found = 1'b1; break; end
    end
    check("t6_reached_run", 64'(found), 64'(1));
    @(negedge clk);
    win_h_num = 11'd2; win_v_num = 11'd1; act_h_num = 11'd0; row_start = 11'd9;
    frame_start = 1'b1; stray_td = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    wait_frame(3000);
    check("t6_pixels", 64'(got_q.size()), 64'(27));
    check("t6_row_done_cnt", 64'(rows_done_cnt), 64'(3));
    check("t6_stray_td_sent", 64'(stray_td), 64'(0));
    if (seen_rows.size() == 3) begin
      check("t6_row0", 64'(seen_rows[0]), 64'(2046));
      check("t6_row2_wrap", 64'(seen_rows[2]), 64'(0));
    end

    // randomized frames
    for (int f = 0; f < 8; f++) begin
      int wh, wv, act;
      wh = $urandom_range(1, 20); wv = $urandom_range(1, 4); act = $urandom_range(0, 24);
      rdy_mode = $urandom_range(0, 2); td_delay = $urandom_range(0, 5);
      start_frame(wh, wv, act, ROW_W'($urandom_range(0, 2047)), DW'($urandom));
      wait_frame(3000);
      check("rand_pixels", 64'(got_q.size()), 64'(wh * wv));
      check("rand_rows", 64'(rows_done_cnt), 64'(wv));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    n_fail++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
